// File: rtl/sum_packer.sv
// Packs successive 4-bit adder sums (S) and their carries (Cout) into one NUM_NIB-slot word.
// Latency: the word is presented 1 cycle after the accept that fills it, or after a flush.
// Backpressure: in_ready drops while a word is presented; one bubble cycle after each drain.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   S, Cout, in_valid input sum nibble + carry; in_ready handshake
//   flush             emit a partially filled word (ignored when empty or already presenting)
//   out_valid/ready   output handshake for P (packed sums, slot 0 in P[3:0]), C (carries),
//                     cnt (valid slot count) and ovf (OR of C)
//   par               only with PACK_PARITY_EN defined: XOR-reduction of P
module sum_packer #(
    parameter int NUM_NIB = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     S,
    input  logic                           Cout,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [4*NUM_NIB-1:0]           P,
    output logic [NUM_NIB-1:0]             C,
    output logic [$clog2(NUM_NIB+1)-1:0]   cnt,
    output logic                           ovf
`ifdef PACK_PARITY_EN
    ,
    output logic                           par
`endif
);
    localparam int CW = $clog2(NUM_NIB + 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_acc;
    logic [CW-1:0]          r_idx;
    logic [CW-1:0]          r_cnt;
    logic [4*NUM_NIB-1:0]   r_p;
    logic [NUM_NIB-1:0]     r_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs. in_ready is gated by rst so nothing
    // is taken during the reset cycle.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_acc     = 1'b0;
        case (r_state)
            ST_FILL: begin
                in_ready = ~rst;
                w_acc    = in_valid & ~rst;
                // Last slot filled, or flush with at least one nibble (stored or arriving now).
                if ((w_acc && (r_idx == CW'(NUM_NIB - 1))) ||
                    (flush && (w_acc || (r_idx != '0)))) begin
                    w_next = ST_FULL;
                end
            end
            ST_FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_FILL;
                end
            end
            default: w_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_p   <= '0;
            r_c   <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_acc) begin
                        for (int i = 0; i < NUM_NIB; i++) begin
                            if (r_idx == CW'(i)) begin
                                r_p[i*4 +: 4] <= S;
                                r_c[i]        <= Cout;
                            end
                        end
                        r_idx <= r_idx + CW'(1);
                    end
                    // cnt includes a nibble accepted in the same cycle as the transition.
                    if (w_next == ST_FULL) begin
                        r_cnt <= w_acc ? (r_idx + CW'(1)) : r_idx;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        r_idx <= '0;
                        r_cnt <= '0;
                        r_p   <= '0;
                        r_c   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign P   = r_p;
    assign C   = r_c;
    assign cnt = r_cnt;
    assign ovf = |r_c;

`ifdef PACK_PARITY_EN
    assign par = ^r_p;
`endif

endmodule

// File: tb/tb_sum_packer.sv
module tb_sum_packer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst, Cout, in_valid, in_ready, flush, out_ready, out_valid, ovf;
    logic [3:0]  S;
    logic [15:0] P;
    logic [3:0]  C;
    logic [2:0]  cnt;
`ifdef PACK_PARITY_EN
    logic        par;
`endif

    sum_packer #(.NUM_NIB(N)) dut (
        .clk(clk), .rst(rst), .S(S), .Cout(Cout), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .P(P), .C(C), .cnt(cnt), .ovf(ovf)
`ifdef PACK_PARITY_EN
        , .par(par)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the collected (carry, sum) pairs in arrival order and
    // whether the word is currently being presented.
    logic [4:0] m_q[$];
    bit         m_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_p();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = v + (16'(m_q[i][3:0]) << (4 * i));
        return v;
    endfunction

    function automatic logic [3:0] exp_c();
        logic [3:0] v = '0;
        foreach (m_q[i]) if (m_q[i][4]) v = v + (4'd1 << i);
        return v;
    endfunction

    // One clock: drive at negedge, check in_ready combinationally, advance the
    // model at the edge and check the registered outputs 1 time unit later.
    task automatic step(input bit v, input logic [3:0] s, input bit co,
                        input bit fl, input bit ordy, input bit r);
        @(negedge clk);
        in_valid = v; S = s; Cout = co; flush = fl; out_ready = ordy; rst = r;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_full && !r));
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_full = 0;
        end else if (m_full) begin
            if (ordy) begin
                m_q.delete();
                m_full = 0;
            end
        end else begin
            if (v) m_q.push_back({co, s});
            if (m_q.size() == N || (fl && m_q.size() > 0)) m_full = 1;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("P", 32'(P), 32'(exp_p()));
        chk("C", 32'(C), 32'(exp_c()));
        chk("cnt", 32'(cnt), m_full ? 32'(m_q.size()) : 32'd0);
        chk("ovf", 32'(ovf), 32'(exp_c() != 0));
`ifdef PACK_PARITY_EN
        chk("par", 32'(par), 32'(^exp_p()));
`endif
    endtask

    initial begin
        in_valid = 0; S = '0; Cout = 0; flush = 0; out_ready = 0; rst = 1;
        m_full = 0;

        // Reset state
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("reset_P", 32'(P), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);

        // Fill with 1,2,3,4
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0, 0);
        chk("fill_P", 32'(P), 32'h4321);
        chk("fill_cnt", 32'(cnt), 32'd4);
`ifdef PACK_PARITY_EN
        chk("fill_par", 32'(par), 32'd1);
`endif

        // Held while out_ready low, in_valid ignored
        for (int i = 0; i < 5; i++) step(1, 4'hF, 1, 0, 0, 0);
        chk("hold_P", 32'(P), 32'h4321);
        step(1, 4'hF, 1, 0, 1, 0);   // drain, no bypass
        chk("drain_P", 32'(P), 32'h0);
        step(0, 0, 0, 0, 0, 0);

        // Partial word with flush
        step(1, 4'hA, 0, 0, 0, 0);
        step(1, 4'hB, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("flush_P", 32'(P), 32'h00BA);
        chk("flush_C", 32'(C), 32'b0010);
        chk("flush_cnt", 32'(cnt), 32'd2);
        chk("flush_ovf", 32'(ovf), 32'd1);
        step(0, 0, 0, 1, 1, 0);      // flush while presenting is ignored

        // Flush on empty is ignored
        step(0, 0, 0, 1, 0, 0);
        chk("empty_flush", 32'(out_valid), 32'd0);

        // Flush coincident with third accept
        step(1, 4'h1, 0, 0, 0, 0);
        step(1, 4'h2, 0, 0, 0, 0);
        step(1, 4'h7, 0, 1, 0, 0);
        chk("flacc_cnt", 32'(cnt), 32'd3);
        chk("flacc_nib", 32'(P[11:8]), 32'h7);
        step(0, 0, 0, 0, 1, 0);

        // Reset mid-word
        for (int i = 0; i < 3; i++) step(1, 4'(9 + i), 1, 0, 0, 0);
        step(1, 4'hE, 1, 0, 0, 1);
        for (int i = 5; i <= 8; i++) step(1, 4'(i), 0, 0, 0, 0);
        chk("rst_mid_P", 32'(P), 32'h8765);
        chk("rst_mid_cnt", 32'(cnt), 32'd4);
        step(0, 0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 60) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sum_packer.md
SUM_PACKER -- requirements
Module: sum_packer

Interface
REQ-001 SHALL have parameter: NUM_NIB, default 4, number of 4-bit sums packed per output word (legal range 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: S  input  4  sum nibble from the upstream 4-bit adder.
REQ-005 SHALL have port: Cout  input  1  carry-out accompanying S.
REQ-006 SHALL have port: in_valid  input  1  S/Cout valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts S/Cout this cycle.
REQ-008 SHALL have port: flush  input  1  request to emit a partially filled word.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the output word.
REQ-010 SHALL have port: out_valid  output  1  P/C/cnt/ovf valid.
REQ-011 SHALL have port: P  output  4*NUM_NIB  packed sums; slot 0 at P[3:0].
REQ-012 SHALL have port: C  output  NUM_NIB  carry flags; C[i] belongs to slot i.
REQ-013 SHALL have port: cnt  output  $clog2(NUM_NIB+1)  number of valid slots in the word.
REQ-014 SHALL have port: ovf  output  1  OR of all C bits.

Function
REQ-015 SHALL implement a two-state FSM: FILL (collecting) and FULL (presenting).
REQ-016 in_ready SHALL be 1 in FILL and 0 in FULL and while rst is high.
REQ-017 An accept (in_valid & in_ready) SHALL write S to slot idx and Cout to C[idx], then increment idx.
REQ-018 An accept at idx = NUM_NIB-1 SHALL move the FSM to FULL, with out_valid = 1 in the next cycle (latency 1) and cnt = NUM_NIB.
REQ-019 In FULL, P, C, cnt, and ovf SHALL be held stable and in_valid SHALL be ignored until out_valid & out_ready.
REQ-020 On out_valid & out_ready, the block SHALL clear P, C, cnt, and idx to 0 and return to FILL; in_ready SHALL be 0 in the draining cycle (no bypass, one-cycle bubble).
REQ-021 flush in FILL with idx > 0 SHALL move the FSM to FULL, with cnt = idx; unfilled slots SHALL read 0.
REQ-022 flush coincident with an accept SHALL first store that nibble and then go to FULL, with cnt = idx+1.
REQ-023 flush in FILL with idx = 0 and no accept SHALL be ignored; flush in FULL SHALL be ignored.
REQ-024 ovf SHALL be combinationally derived from the registered C.

Reset
REQ-025 With rst high at a clock edge, the block SHALL set state to FILL and set idx, P, C, cnt, ovf, and out_valid to 0.
REQ-026 Reset mid-word SHALL discard all collected nibbles; the next accept after reset SHALL go to slot 0.

Configuration
REQ-027 Macro PACK_PARITY_EN: when defined, the block SHALL add output port par (1 bit) = XOR-reduction of P, valid with out_valid and 0 after reset.
REQ-028 When PACK_PARITY_EN is undefined, port par and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (NUM_NIB = 4)
REQ-029 Reset, then accept S = 1, 2, 3, 4 with Cout = 0 -> out_valid = 1 in the cycle after the 4th accept; P = 16'h4321, C = 4'b0000, cnt = 4, ovf = 0.
REQ-030 After REQ-029, hold out_ready = 0 for 5 cycles with in_valid = 1 -> P held at 16'h4321, in_ready = 0, no slot written; then out_ready = 1 -> outputs clear, and in_ready = 1 one cycle later.
REQ-031 Accept S = 4'hA (Cout = 0), then S = 4'hB (Cout = 1), then flush -> P = 16'h00BA, C = 4'b0010, cnt = 2, ovf = 1.
REQ-032 Accept 2 nibbles, then flush together with a 3rd accept S = 4'h7 -> cnt = 3, P[11:8] = 4'h7.
REQ-033 Accept 3 nibbles, assert rst for 1 cycle, then accept S = 5, 6, 7, 8 -> P = 16'h8765, cnt = 4.
REQ-034 With PACK_PARITY_EN defined, fill with 1, 2, 3, 4 -> P = 16'h4321, par = 1.
